// File: rtl/usb_pkg.sv
// Shared definitions for the lab USB device responder: packet IDs, responder
// states and the encoder request kinds.
package usb_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010
    } pid_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OUT_WDATA,
        ST_IN_SEND,
        ST_IN_WACK,
        ST_SEND_HS
    } state_t;

    localparam logic TX_KIND_HS   = 1'b0;
    localparam logic TX_KIND_DATA = 1'b1;

endpackage

// File: rtl/usb_device_responder_timer.sv
// Wait-state timeout counter: runs while enabled, clears whenever disabled, and
// flags the last allowed cycle of the wait window.
module usb_device_responder_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (!expired) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/usb_device_responder.sv
// Device-side responder for the lab USB protocol: answers OUT with ACK/NAK and IN
// with DATA0, holding one receive and one transmit buffer for the application.
module usb_device_responder
    import usb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'd5,
    parameter logic [3:0] ENDP       = 4'd3,
    parameter int         RX_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pkt_valid,
    input  logic [3:0]  pkt_pid,
    input  logic [6:0]  pkt_addr,
    input  logic [3:0]  pkt_endp,
    input  logic [63:0] pkt_data,
    input  logic        pkt_corrupted,
    output logic        tx_valid,
    output logic        tx_kind,
    output logic [3:0]  tx_pid,
    output logic [63:0] tx_data,
    input  logic        tx_ready,
    output logic        app_out_valid,
    output logic [63:0] app_out_data,
    input  logic        app_out_pop,
    input  logic        app_in_load,
    input  logic [63:0] app_in_data,
    output logic        app_in_full,
    output logic        app_in_done,
    output logic [7:0]  err_cnt
);

    state_t      state_q, state_d, ret_q, ret_d;
    logic        tx_valid_q, tx_valid_d, tx_kind_q, tx_kind_d;
    logic [3:0]  tx_pid_q, tx_pid_d;
    logic [63:0] tx_data_q, tx_data_d;
    logic        out_valid_q, out_valid_d, in_full_q, in_full_d, in_done_q, in_done_d;
    logic [63:0] out_data_q, out_data_d, in_buf_q, in_buf_d;
    logic [7:0]  err_q, err_d;
    logic        pkt_good, tok_match, tx_accept, ack_release;
    logic        timer_run, timer_expired;

    assign pkt_good  = pkt_valid & ~pkt_corrupted;
    assign tok_match = pkt_good && (pkt_addr == DEV_ADDR) && (pkt_endp == ENDP);
    assign tx_accept = tx_valid_q & tx_ready;
    assign timer_run = (state_q == ST_OUT_WDATA) || (state_q == ST_IN_WACK);

    usb_device_responder_timer #(.LIMIT(RX_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (timer_run),
        .expired (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        tx_valid_d  = tx_valid_q;
        tx_kind_d   = tx_kind_q;
        tx_pid_d    = tx_pid_q;
        tx_data_d   = tx_data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        in_full_d   = in_full_q;
        in_buf_d    = in_buf_q;
        in_done_d   = 1'b0;
        err_d       = err_q;
        ack_release = 1'b0;

        if (pkt_valid && pkt_corrupted && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
        if (tx_accept) begin
            tx_valid_d = 1'b0;
        end
        // A capture can only happen when the buffer is empty, so a pop never races it.
        if (app_out_pop && out_valid_q) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (tok_match && (pkt_pid == PID_OUT)) begin
                    state_d = ST_OUT_WDATA;
                end else if (tok_match && (pkt_pid == PID_IN)) begin
                    tx_valid_d = 1'b1;
                    if (in_full_q) begin
                        state_d   = ST_IN_SEND;
                        tx_kind_d = TX_KIND_DATA;
                        tx_pid_d  = PID_DATA0;
                        tx_data_d = in_buf_q;
                    end else begin
                        state_d   = ST_SEND_HS;
                        ret_d     = ST_IDLE;
                        tx_kind_d = TX_KIND_HS;
                        tx_pid_d  = PID_NAK;
                        tx_data_d = '0;
                    end
                end
            end
            ST_OUT_WDATA: begin
                if (pkt_valid && (pkt_pid == PID_DATA0)) begin
                    state_d    = ST_SEND_HS;
                    tx_valid_d = 1'b1;
                    tx_kind_d  = TX_KIND_HS;
                    tx_data_d  = '0;
                    if (pkt_corrupted) begin
                        tx_pid_d = PID_NAK;
                        ret_d    = ST_OUT_WDATA;
                    end else if (!out_valid_q) begin
                        tx_pid_d    = PID_ACK;
                        ret_d       = ST_IDLE;
                        out_valid_d = 1'b1;
                        out_data_d  = pkt_data;
                    end else begin
                        tx_pid_d = PID_NAK;
                        ret_d    = ST_IDLE;
                    end
                end else if (timer_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IN_SEND: begin
                if (tx_accept) begin
                    state_d = ST_IN_WACK;
                end
            end
            ST_IN_WACK: begin
                if (pkt_good && (pkt_pid == PID_ACK)) begin
                    state_d     = ST_IDLE;
                    ack_release = 1'b1;
                    in_done_d   = 1'b1;
                end else if (pkt_good && (pkt_pid == PID_NAK)) begin
                    state_d    = ST_IN_SEND;
                    tx_valid_d = 1'b1;
                    tx_kind_d  = TX_KIND_DATA;
                    tx_pid_d   = PID_DATA0;
                    tx_data_d  = in_buf_q;
                end else if (timer_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND_HS: begin
                if (tx_accept) begin
                    state_d = ret_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A load in the same cycle as the host ACK refills the buffer immediately.
        if (app_in_load && (!in_full_q || ack_release)) begin
            in_buf_d  = app_in_data;
            in_full_d = 1'b1;
        end else if (ack_release) begin
            in_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ret_q       <= ST_IDLE;
            tx_valid_q  <= 1'b0;
            tx_kind_q   <= 1'b0;
            tx_pid_q    <= '0;
            tx_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            in_full_q   <= 1'b0;
            in_buf_q    <= '0;
            in_done_q   <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            tx_valid_q  <= tx_valid_d;
            tx_kind_q   <= tx_kind_d;
            tx_pid_q    <= tx_pid_d;
            tx_data_q   <= tx_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            in_full_q   <= in_full_d;
            in_buf_q    <= in_buf_d;
            in_done_q   <= in_done_d;
            err_q       <= err_d;
        end
    end

    assign tx_valid      = tx_valid_q;
    assign tx_kind       = tx_kind_q;
    assign tx_pid        = tx_pid_q;
    assign tx_data       = tx_data_q;
    assign app_out_valid = out_valid_q;
    assign app_out_data  = out_data_q;
    assign app_in_full   = in_full_q;
    assign app_in_done   = in_done_q;
    assign err_cnt       = err_q;

endmodule

// File: tb/tb_usb_device_responder.sv
// Bench for usb_device_responder: a table of directed transactions, hand-written
// corner sequences, and random transactions against a transaction-level model.
module tb_usb_device_responder;
    import usb_pkg::*;

    localparam int RX_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_valid, pkt_corrupted;
    logic [3:0]  pkt_pid, pkt_endp;
    logic [6:0]  pkt_addr;
    logic [63:0] pkt_data;
    logic        tx_valid, tx_kind, tx_ready;
    logic [3:0]  tx_pid;
    logic [63:0] tx_data;
    logic        app_out_valid, app_out_pop, app_in_load, app_in_full, app_in_done;
    logic [63:0] app_out_data, app_in_data;
    logic [7:0]  err_cnt;

    usb_device_responder #(.DEV_ADDR(7'd5), .ENDP(4'd3), .RX_TIMEOUT(RX_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .pkt_valid(pkt_valid), .pkt_pid(pkt_pid), .pkt_addr(pkt_addr), .pkt_endp(pkt_endp),
        .pkt_data(pkt_data), .pkt_corrupted(pkt_corrupted),
        .tx_valid(tx_valid), .tx_kind(tx_kind), .tx_pid(tx_pid), .tx_data(tx_data),
        .tx_ready(tx_ready),
        .app_out_valid(app_out_valid), .app_out_data(app_out_data), .app_out_pop(app_out_pop),
        .app_in_load(app_in_load), .app_in_data(app_in_data), .app_in_full(app_in_full),
        .app_in_done(app_in_done), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    logic done_seen;

    typedef enum int {OP_TOK_OUT, OP_TOK_IN, OP_DATA, OP_ACK, OP_NAK, OP_LOAD, OP_POP} op_e;
    typedef struct {
        op_e         op;
        logic [6:0]  addr;
        logic        cor;
        logic [63:0] data;
        int          resp;   // 0 none, 1 handshake, 2 DATA0
        logic [3:0]  rpid;
        logic [63:0] rdata;
        logic        ov;
        logic [63:0] od;
        logic        inf;
        logic [7:0]  err;
    } vec_t;
    vec_t tbl[$];

    // Transaction-level model state
    logic        m_ov, m_inf;
    logic [63:0] m_od, m_buf;
    int          m_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic host_pkt(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                            input logic [63:0] data, input logic cor);
        @(negedge clk);
        pkt_valid = 1'b1; pkt_pid = pid; pkt_addr = addr; pkt_endp = endp;
        pkt_data = data; pkt_corrupted = cor;
        @(negedge clk);
        pkt_valid = 1'b0; pkt_corrupted = 1'b0;
        done_seen = app_in_done;
    endtask

    task automatic app_load(input logic [63:0] d);
        @(negedge clk);
        app_in_load = 1'b1; app_in_data = d;
        @(negedge clk);
        app_in_load = 1'b0;
    endtask

    task automatic app_pop();
        @(negedge clk);
        app_out_pop = 1'b1;
        @(negedge clk);
        app_out_pop = 1'b0;
    endtask

    task automatic expect_tx(input logic kind, input logic [3:0] pid, input logic [63:0] data,
                             input int stall, input string nm);
        int   n = 0;
        logic stable = 1'b1;
        while (tx_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " tx_valid"}, 64'(tx_valid), 64'd1);
        if (tx_valid === 1'b1) begin
            chk({nm, " tx_kind"}, 64'(tx_kind), 64'(kind));
            chk({nm, " tx_pid"}, 64'(tx_pid), 64'(pid));
            if (kind) chk({nm, " tx_data"}, tx_data, data);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (tx_valid !== 1'b1 || tx_pid !== pid || tx_kind !== kind) stable = 1'b0;
            end
            if (stall > 0) chk({nm, " held"}, 64'(stable), 64'd1);
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
            chk({nm, " tx_valid drop"}, 64'(tx_valid), 64'd0);
        end
    endtask

    task automatic expect_quiet(input int cycles, input string nm);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (tx_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        if (tx_valid !== 1'b0) seen = 1'b1;
        chk({nm, " no tx"}, 64'(seen), 64'd0);
    endtask

    task automatic add(input op_e op, input logic [6:0] addr, input logic cor, input logic [63:0] data,
                       input int resp, input logic [3:0] rpid, input logic [63:0] rdata,
                       input logic ov, input logic [63:0] od, input logic inf, input logic [7:0] err);
        vec_t v;
        v.op = op; v.addr = addr; v.cor = cor; v.data = data; v.resp = resp; v.rpid = rpid;
        v.rdata = rdata; v.ov = ov; v.od = od; v.inf = inf; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic check_model(input string nm);
        chk({nm, " out_valid"}, 64'(app_out_valid), 64'(m_ov));
        if (m_ov) chk({nm, " out_data"}, app_out_data, m_od);
        chk({nm, " in_full"}, 64'(app_in_full), 64'(m_inf));
        chk({nm, " err_cnt"}, 64'(err_cnt), 64'(m_err));
    endtask

    task automatic model_out_data(input logic [63:0] d, input int stall, input string nm);
        host_pkt(PID_DATA0, 7'd0, 4'd0, d, 1'b0);
        if (!m_ov) begin
            expect_tx(TX_KIND_HS, PID_ACK, 64'd0, stall, nm);
            m_ov = 1'b1; m_od = d;
        end else begin
            expect_tx(TX_KIND_HS, PID_NAK, 64'd0, stall, nm);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; pkt_valid = 1'b0; pkt_corrupted = 1'b0; pkt_pid = '0; pkt_addr = '0;
        pkt_endp = '0; pkt_data = '0; tx_ready = 1'b0; app_out_pop = 1'b0; app_in_load = 1'b0;
        app_in_data = '0; done_seen = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset tx_valid", 64'(tx_valid), 64'd0);
        chk("reset tx_pid", 64'(tx_pid), 64'd0);
        chk("reset out_valid", 64'(app_out_valid), 64'd0);
        chk("reset in_full", 64'(app_in_full), 64'd0);
        chk("reset in_done", 64'(app_in_done), 64'd0);
        chk("reset err_cnt", 64'(err_cnt), 64'd0);
        rst = 1'b0;

        //  op          addr  cor data            resp pid        rdata           ov od             inf err
        add(OP_TOK_OUT, 7'd5, 0, 64'h0,           0, 4'h0,      64'h0,          0, 64'h0,          0, 0);
        add(OP_DATA,    7'd0, 0, 64'hAABBCCDD,    1, PID_ACK,   64'h0,          1, 64'hAABBCCDD,   0, 0);
        add(OP_POP,     7'd0, 0, 64'h0,           0, 4'h0,      64'h0,          0, 64'h0,          0, 0);
        add(OP_TOK_OUT, 7'd5, 0, 64'h0,           0, 4'h0,      64'h0,          0, 64'h0,          0, 0);
        add(OP_DATA,    7'd0, 1, 64'hFFFF,        1, PID_NAK,   64'h0,          0, 64'h0,          0, 1);
        add(OP_DATA,    7'd0, 0, 64'h1234,        1, PID_ACK,   64'h0,          1, 64'h1234,       0, 1);
        add(OP_TOK_OUT, 7'd5, 0, 64'h0,           0, 4'h0,      64'h0,          1, 64'h1234,       0, 1);
        add(OP_DATA,    7'd0, 0, 64'h5555,        1, PID_NAK,   64'h0,          1, 64'h1234,       0, 1);
        add(OP_TOK_OUT, 7'd6, 0, 64'h0,           0, 4'h0,      64'h0,          1, 64'h1234,       0, 1);
        add(OP_DATA,    7'd0, 0, 64'h7777,        0, 4'h0,      64'h0,          1, 64'h1234,       0, 1);
        add(OP_TOK_OUT, 7'd5, 1, 64'h0,           0, 4'h0,      64'h0,          1, 64'h1234,       0, 2);
        add(OP_DATA,    7'd0, 0, 64'h8888,        0, 4'h0,      64'h0,          1, 64'h1234,       0, 2);
        add(OP_TOK_IN,  7'd5, 0, 64'h0,           1, PID_NAK,   64'h0,          1, 64'h1234,       0, 2);
        add(OP_LOAD,    7'd0, 0, 64'hDEADBEEF,    0, 4'h0,      64'h0,          1, 64'h1234,       1, 2);
        add(OP_TOK_IN,  7'd5, 0, 64'h0,           2, PID_DATA0, 64'hDEADBEEF,   1, 64'h1234,       1, 2);
        add(OP_NAK,     7'd0, 0, 64'h0,           2, PID_DATA0, 64'hDEADBEEF,   1, 64'h1234,       1, 2);
        add(OP_ACK,     7'd0, 0, 64'h0,           0, 4'h0,      64'h0,          1, 64'h1234,       0, 2);
        add(OP_POP,     7'd0, 0, 64'h0,           0, 4'h0,      64'h0,          0, 64'h0,          0, 2);

        foreach (tbl[i]) begin
            string nm;
            nm = $sformatf("step%0d", i);
            case (tbl[i].op)
                OP_TOK_OUT: host_pkt(PID_OUT, tbl[i].addr, 4'd3, 64'd0, tbl[i].cor);
                OP_TOK_IN:  host_pkt(PID_IN, tbl[i].addr, 4'd3, 64'd0, tbl[i].cor);
                OP_DATA:    host_pkt(PID_DATA0, tbl[i].addr, 4'd0, tbl[i].data, tbl[i].cor);
                OP_ACK:     host_pkt(PID_ACK, 7'd0, 4'd0, 64'd0, tbl[i].cor);
                OP_NAK:     host_pkt(PID_NAK, 7'd0, 4'd0, 64'd0, tbl[i].cor);
                OP_LOAD:    app_load(tbl[i].data);
                default:    app_pop();
            endcase
            if (tbl[i].resp == 0) expect_quiet(4, nm);
            else expect_tx(tbl[i].resp == 2, tbl[i].rpid, tbl[i].rdata, 0, nm);
            chk({nm, " out_valid"}, 64'(app_out_valid), 64'(tbl[i].ov));
            if (tbl[i].ov) chk({nm, " out_data"}, app_out_data, tbl[i].od);
            chk({nm, " in_full"}, 64'(app_in_full), 64'(tbl[i].inf));
            chk({nm, " err_cnt"}, 64'(err_cnt), 64'(tbl[i].err));
        end

        // Encoder stalls 5 cycles on DATA0; host ACK gives a single-cycle done pulse.
        app_load(64'h1111_2222);
        host_pkt(PID_IN, 7'd5, 4'd3, 64'd0, 1'b0);
        expect_tx(TX_KIND_DATA, PID_DATA0, 64'h1111_2222, 5, "stall");
        host_pkt(PID_ACK, 7'd0, 4'd0, 64'd0, 1'b0);
        chk("done pulse", 64'(done_seen), 64'd1);
        @(negedge clk);
        chk("done pulse width", 64'(app_in_done), 64'd0);
        chk("done in_full", 64'(app_in_full), 64'd0);

        // Host never answers DATA0: buffer retained, load while full ignored.
        app_load(64'hCAFE);
        host_pkt(PID_IN, 7'd5, 4'd3, 64'd0, 1'b0);
        expect_tx(TX_KIND_DATA, PID_DATA0, 64'hCAFE, 0, "in timeout");
        expect_quiet(RX_TIMEOUT + 4, "in timeout wait");
        chk("in timeout in_full", 64'(app_in_full), 64'd1);
        app_load(64'hBAD);
        host_pkt(PID_IN, 7'd5, 4'd3, 64'd0, 1'b0);
        expect_tx(TX_KIND_DATA, PID_DATA0, 64'hCAFE, 0, "in retry");

        // Load in the same cycle as the releasing ACK.
        @(negedge clk);
        pkt_valid = 1'b1; pkt_pid = PID_ACK; pkt_corrupted = 1'b0;
        app_in_load = 1'b1; app_in_data = 64'h2;
        @(negedge clk);
        pkt_valid = 1'b0; app_in_load = 1'b0;
        chk("ack+load done", 64'(app_in_done), 64'd1);
        chk("ack+load in_full", 64'(app_in_full), 64'd1);
        host_pkt(PID_IN, 7'd5, 4'd3, 64'd0, 1'b0);
        expect_tx(TX_KIND_DATA, PID_DATA0, 64'h2, 1, "ack+load resend");
        host_pkt(PID_ACK, 7'd0, 4'd0, 64'd0, 1'b0);

        // OUT with no DATA0 times out; a late DATA0 is a stray packet.
        host_pkt(PID_OUT, 7'd5, 4'd3, 64'd0, 1'b0);
        expect_quiet(RX_TIMEOUT + 4, "out timeout wait");
        host_pkt(PID_DATA0, 7'd0, 4'd0, 64'h99, 1'b0);
        expect_quiet(4, "out late data");
        chk("out late out_valid", 64'(app_out_valid), 64'd0);

        // Pop in the same cycle as capture: capture wins.
        host_pkt(PID_OUT, 7'd5, 4'd3, 64'd0, 1'b0);
        @(negedge clk);
        pkt_valid = 1'b1; pkt_pid = PID_DATA0; pkt_data = 64'h4242; app_out_pop = 1'b1;
        @(negedge clk);
        pkt_valid = 1'b0; app_out_pop = 1'b0;
        expect_tx(TX_KIND_HS, PID_ACK, 64'd0, 0, "pop+capture");
        chk("pop+capture out_valid", 64'(app_out_valid), 64'd1);
        chk("pop+capture out_data", app_out_data, 64'h4242);

        // Reset while waiting for the host handshake.
        app_load(64'h5A);
        host_pkt(PID_IN, 7'd5, 4'd3, 64'd0, 1'b0);
        expect_tx(TX_KIND_DATA, PID_DATA0, 64'h5A, 0, "rst in");
        rst = 1'b1;
        @(negedge clk);
        chk("rst tx_valid", 64'(tx_valid), 64'd0);
        chk("rst tx_data", tx_data, 64'd0);
        chk("rst out_valid", 64'(app_out_valid), 64'd0);
        chk("rst out_data", app_out_data, 64'd0);
        chk("rst in_full", 64'(app_in_full), 64'd0);
        chk("rst err_cnt", 64'(err_cnt), 64'd0);
        rst = 1'b0;
        host_pkt(PID_IN, 7'd5, 4'd3, 64'd0, 1'b0);
        expect_tx(TX_KIND_HS, PID_NAK, 64'd0, 0, "rst after in");

        // Random transactions against the model.
        m_ov = 1'b0; m_inf = 1'b0; m_od = '0; m_buf = '0; m_err = 0;
        for (int it = 0; it < 150; it++) begin
            string       nm;
            logic [63:0] d;
            int          stall;
            logic        cor;
            nm = $sformatf("rand%0d", it);
            d = {$urandom, $urandom};
            stall = $urandom_range(0, 3);
            case ($urandom_range(0, 6))
                0: begin
                    host_pkt(PID_OUT, 7'd5, 4'd3, 64'd0, 1'b0);
                    expect_quiet(2, nm);
                    model_out_data(d, stall, nm);
                end
                1: begin
                    host_pkt(PID_OUT, 7'd5, 4'd3, 64'd0, 1'b0);
                    host_pkt(PID_DATA0, 7'd0, 4'd0, ~d, 1'b1);
                    m_err++;
                    expect_tx(TX_KIND_HS, PID_NAK, 64'd0, stall, nm);
                    model_out_data(d, 0, nm);
                end
                2: begin
                    host_pkt(PID_IN, 7'd5, 4'd3, 64'd0, 1'b0);
                    if (m_inf) begin
                        expect_tx(TX_KIND_DATA, PID_DATA0, m_buf, stall, nm);
                        if ($urandom_range(0, 1) == 1) begin
                            host_pkt(PID_NAK, 7'd0, 4'd0, 64'd0, 1'b0);
                            expect_tx(TX_KIND_DATA, PID_DATA0, m_buf, 0, {nm, " resend"});
                        end
                        host_pkt(PID_ACK, 7'd0, 4'd0, 64'd0, 1'b0);
                        chk({nm, " done"}, 64'(done_seen), 64'd1);
                        m_inf = 1'b0;
                    end else begin
                        expect_tx(TX_KIND_HS, PID_NAK, 64'd0, stall, nm);
                    end
                end
                3: begin
                    app_load(d);
                    if (!m_inf) begin
                        m_inf = 1'b1; m_buf = d;
                    end
                end
                4: begin
                    app_pop();
                    m_ov = 1'b0;
                end
                5: begin
                    cor = 1'($urandom_range(0, 1));
                    host_pkt(($urandom_range(0, 1) == 1) ? PID_IN : PID_OUT,
                             cor ? 7'd5 : 7'($urandom_range(6, 127)), 4'd3, 64'd0, cor);
                    if (cor) m_err++;
                    expect_quiet(3, nm);
                end
                default: begin
                    host_pkt(($urandom_range(0, 1) == 1) ? PID_ACK : PID_DATA0, 7'd5, 4'd3, d, 1'b0);
                    expect_quiet(3, nm);
                end
            endcase
            check_model(nm);
        end

        // Error counter saturation.
        while (m_err < 254) begin
            host_pkt(PID_ACK, 7'd0, 4'd0, 64'd0, 1'b1);
            m_err++;
        end
        chk("err_cnt 254", 64'(err_cnt), 64'd254);
        repeat (10) host_pkt(PID_ACK, 7'd0, 4'd0, 64'd0, 1'b1);
        chk("err_cnt saturated", 64'(err_cnt), 64'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
